// File: rtl/fwts_pkg.sv
// Shared lamp encodings, phase/state enums and fault codes for the conflict monitor.
package fwts_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b001;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b100;

    typedef enum logic [2:0] {
        PH_NS_G,
        PH_NS_Y,
        PH_EW_G,
        PH_EW_Y,
        PH_ALL_R,
        PH_INVALID
    } phase_e;

    localparam logic [2:0] FC_NONE         = 3'd0;
    localparam logic [2:0] FC_ILLEGAL      = 3'd1;
    localparam logic [2:0] FC_CONFLICT     = 3'd2;
    localparam logic [2:0] FC_PAIR         = 3'd3;
    localparam logic [2:0] FC_SEQUENCE     = 3'd4;
    localparam logic [2:0] FC_SHORT_YELLOW = 3'd5;
    localparam logic [2:0] FC_SHORT_CLEAR  = 3'd6;
    localparam logic [2:0] FC_STUCK        = 3'd7;

    typedef enum logic [1:0] {
        ST_ARM,
        ST_MONITOR,
        ST_FAULT
    } mon_state_e;

    // Only the controller's nominal rotation is a legal phase change.
    function automatic logic legal_step(input phase_e from_ph, input phase_e to_ph);
        logic ok;
        ok = 1'b0;
        case (from_ph)
            PH_NS_G:  ok = (to_ph == PH_NS_Y);
            PH_NS_Y:  ok = (to_ph == PH_ALL_R);
            PH_EW_G:  ok = (to_ph == PH_EW_Y);
            PH_EW_Y:  ok = (to_ph == PH_ALL_R);
            PH_ALL_R: ok = (to_ph == PH_NS_G) || (to_ph == PH_EW_G);
            default:  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/fwts_phase_decode.sv
// Combinational classifier: four lamp codes -> phase plus illegal/conflict/pair flags.
module fwts_phase_decode
    import fwts_pkg::*;
(
    input  logic [2:0] north,
    input  logic [2:0] south,
    input  logic [2:0] east,
    input  logic [2:0] west,
    output phase_e     phase,
    output logic       illegal,
    output logic       conflict,
    output logic       pair_mismatch
);

    assign illegal = !$onehot(north) || !$onehot(south) ||
                     !$onehot(east)  || !$onehot(west);

    assign conflict = ((north != LAMP_RED) || (south != LAMP_RED)) &&
                      ((east  != LAMP_RED) || (west  != LAMP_RED));

    assign pair_mismatch = (north != south) || (east != west);

    always_comb begin
        phase = PH_INVALID;
        if ((east == LAMP_RED) && (west == LAMP_RED) && (north == south)) begin
            if (north == LAMP_GREEN) begin
                phase = PH_NS_G;
            end else if (north == LAMP_YELLOW) begin
                phase = PH_NS_Y;
            end else if (north == LAMP_RED) begin
                phase = PH_ALL_R;
            end
        end else if ((north == LAMP_RED) && (south == LAMP_RED) && (east == west)) begin
            if (east == LAMP_GREEN) begin
                phase = PH_EW_G;
            end else if (east == LAMP_YELLOW) begin
                phase = PH_EW_Y;
            end
        end
    end

endmodule

// File: rtl/fwts_conflict_monitor.sv
// Safety monitor for the four-way signal lamp buses; latches the first fault until cleared.
// Define FWTS_MON_STUCK_EN to enable the stuck-phase check (fault code 7).
module fwts_conflict_monitor
    import fwts_pkg::*;
#(
    parameter int T_YELLOW_MIN = 10,
    parameter int T_RED_MIN    = 5,
    parameter int T_STUCK      = 100,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] north,
    input  logic [2:0] south,
    input  logic [2:0] east,
    input  logic [2:0] west,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_cnt
);

    localparam logic [CNT_W-1:0] Y_MIN = CNT_W'(T_YELLOW_MIN);
    localparam logic [CNT_W-1:0] R_MIN = CNT_W'(T_RED_MIN);
`ifdef FWTS_MON_STUCK_EN
    localparam logic [CNT_W-1:0] DUR_MAX   = '1;
    localparam logic [CNT_W-1:0] STUCK_LIM = CNT_W'(T_STUCK);
`else
    // Without the stuck check the counter only has to resolve the minimum intervals.
    localparam logic [CNT_W-1:0] DUR_MAX = (Y_MIN > R_MIN) ? Y_MIN : R_MIN;
`endif

    if (T_STUCK >= (1 << CNT_W)) begin : g_cnt_w_check
        $error("CNT_W is too narrow to hold T_STUCK");
    end

    phase_e           phase;
    logic             illegal, conflict, pair_mismatch;
    mon_state_e       state_q, state_d;
    phase_e           prev_phase_q, prev_phase_d;
    logic [CNT_W-1:0] dur_q, dur_d, dur_inc;
    logic             fault_q, fault_d;
    logic [2:0]       fault_code_q, fault_code_d;
    logic [7:0]       fault_cnt_q, fault_cnt_d;
    logic             phase_changed, check_all, stuck_hit;
    logic [2:0]       det_code;

    fwts_phase_decode u_decode (
        .north         (north),
        .south         (south),
        .east          (east),
        .west          (west),
        .phase         (phase),
        .illegal       (illegal),
        .conflict      (conflict),
        .pair_mismatch (pair_mismatch)
    );

    assign phase_changed = (phase != prev_phase_q);
    assign dur_inc       = (dur_q >= DUR_MAX) ? dur_q : dur_q + 1'b1;
    assign check_all     = (state_q == ST_MONITOR);
`ifdef FWTS_MON_STUCK_EN
    assign stuck_hit = (dur_q >= STUCK_LIM);
`else
    assign stuck_hit = 1'b0;
`endif

    // dur_q is the held length of the phase being left when phase_changed is set.
    always_comb begin
        det_code = FC_NONE;
        if (illegal) begin
            det_code = FC_ILLEGAL;
        end else if (conflict) begin
            det_code = FC_CONFLICT;
        end else if (pair_mismatch) begin
            det_code = FC_PAIR;
        end else if (check_all && phase_changed && !legal_step(prev_phase_q, phase)) begin
            det_code = FC_SEQUENCE;
        end else if (check_all && phase_changed && dur_q < Y_MIN &&
                     (prev_phase_q == PH_NS_Y || prev_phase_q == PH_EW_Y)) begin
            det_code = FC_SHORT_YELLOW;
        end else if (check_all && phase_changed && dur_q < R_MIN &&
                     prev_phase_q == PH_ALL_R) begin
            det_code = FC_SHORT_CLEAR;
        end else if (stuck_hit) begin
            det_code = FC_STUCK;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_phase_d = prev_phase_q;
        dur_d        = dur_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        fault_cnt_d  = fault_cnt_q;
        case (state_q)
            ST_ARM, ST_MONITOR: begin
                prev_phase_d = phase;
                dur_d        = phase_changed ? {{(CNT_W-1){1'b0}}, 1'b1} : dur_inc;
                if (det_code != FC_NONE) begin
                    state_d      = ST_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = det_code;
                    fault_cnt_d  = (fault_cnt_q == 8'hFF) ? fault_cnt_q : fault_cnt_q + 8'd1;
                end else if (state_q == ST_ARM && phase_changed) begin
                    state_d = ST_MONITOR;
                end
            end
            ST_FAULT: begin
                if (fault_clr) begin
                    state_d      = ST_ARM;
                    prev_phase_d = PH_ALL_R;
                    dur_d        = '0;
                    fault_d      = 1'b0;
                    fault_code_d = FC_NONE;
                end
            end
            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_ARM;
            prev_phase_q <= PH_ALL_R;
            dur_q        <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
            fault_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            prev_phase_q <= prev_phase_d;
            dur_q        <= dur_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            fault_cnt_q  <= fault_cnt_d;
        end
    end

    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign fault_cnt  = fault_cnt_q;

endmodule

// File: tb/tb_fwts_conflict_monitor.sv
// Bench for fwts_conflict_monitor: directed scenarios plus randomized lamp traffic against a reference model.
module tb_fwts_conflict_monitor;

    localparam logic [2:0] R = 3'b001;
    localparam logic [2:0] Y = 3'b010;
    localparam logic [2:0] G = 3'b100;

    localparam int P_NSG = 0, P_NSY = 1, P_EWG = 2, P_EWY = 3, P_ALLR = 4, P_INV = 5;
    localparam int M_ARM = 0, M_MON = 1, M_FAULT = 2;
`ifdef FWTS_MON_STUCK_EN
    localparam int STUCK_EN = 1;
`else
    localparam int STUCK_EN = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] north = R, south = R, east = R, west = R;
    logic       fault_clr = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_cnt;

    int n_chk = 0;
    int n_pass = 0;

    int m_mode, m_prev, m_run, m_fault, m_code, m_cnt;

    always #5 clk = ~clk;

    fwts_conflict_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .north      (north),
        .south      (south),
        .east       (east),
        .west       (west),
        .fault_clr  (fault_clr),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_cnt  (fault_cnt)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int classify(input logic [2:0] n, s, e, w);
        if (n == G && s == G && e == R && w == R) return P_NSG;
        if (n == Y && s == Y && e == R && w == R) return P_NSY;
        if (e == G && w == G && n == R && s == R) return P_EWG;
        if (e == Y && w == Y && n == R && s == R) return P_EWY;
        if (n == R && s == R && e == R && w == R) return P_ALLR;
        return P_INV;
    endfunction

    function automatic int legal(input int a, input int b);
        return int'((a == P_NSG && b == P_NSY) || (a == P_NSY && b == P_ALLR) ||
                    (a == P_EWG && b == P_EWY) || (a == P_EWY && b == P_ALLR) ||
                    (a == P_ALLR && (b == P_NSG || b == P_EWG)));
    endfunction

    task automatic model_step(input logic [2:0] n, s, e, w, input logic clr, input logic r);
        int ph, code, chg;
        int viol[8];
        if (!r) begin
            m_mode = M_ARM; m_prev = P_ALLR; m_run = 0;
            m_fault = 0; m_code = 0; m_cnt = 0;
            return;
        end
        if (m_mode == M_FAULT) begin
            if (clr) begin
                m_mode = M_ARM; m_prev = P_ALLR; m_run = 0; m_fault = 0; m_code = 0;
            end
            return;
        end
        ph  = classify(n, s, e, w);
        chg = int'(ph != m_prev);
        for (int c = 0; c < 8; c++) viol[c] = 0;
        viol[1] = int'($countones(n) != 1 || $countones(s) != 1 ||
                       $countones(e) != 1 || $countones(w) != 1);
        viol[2] = int'((n != R || s != R) && (e != R || w != R));
        viol[3] = int'(n != s || e != w);
        if (m_mode == M_MON && chg != 0) begin
            viol[4] = int'(legal(m_prev, ph) == 0);
            viol[5] = int'((m_prev == P_NSY || m_prev == P_EWY) && m_run < 10);
            viol[6] = int'(m_prev == P_ALLR && m_run < 5);
        end
        viol[7] = int'(STUCK_EN != 0 && m_run >= 100);
        code = 0;
        for (int c = 7; c >= 1; c--) if (viol[c] != 0) code = c;
        m_run  = (chg != 0) ? 1 : m_run + 1;
        m_prev = ph;
        if (code != 0) begin
            m_mode = M_FAULT; m_fault = 1; m_code = code;
            if (m_cnt < 255) m_cnt++;
        end else if (m_mode == M_ARM && chg != 0) begin
            m_mode = M_MON;
        end
    endtask

    task automatic cyc(input logic [2:0] n, s, e, w, input logic clr, input logic r);
        north = n; south = s; east = e; west = w; fault_clr = clr; rst = r;
        @(posedge clk);
        #1;
        model_step(n, s, e, w, clr, r);
        chk("fault", int'(fault), m_fault);
        chk("fault_code", int'(fault_code), m_code);
        chk("fault_cnt", int'(fault_cnt), m_cnt);
    endtask

    task automatic lamps(input int ph, output logic [2:0] n, s, e, w);
        n = R; s = R; e = R; w = R;
        case (ph)
            P_NSG: begin n = G; s = G; end
            P_NSY: begin n = Y; s = Y; end
            P_EWG: begin e = G; w = G; end
            P_EWY: begin e = Y; w = Y; end
            default: ;
        endcase
    endtask

    task automatic hold(input int ph, input int n_cyc);
        logic [2:0] n, s, e, w;
        lamps(ph, n, s, e, w);
        for (int i = 0; i < n_cyc; i++) cyc(n, s, e, w, 1'b0, 1'b1);
    endtask

    task automatic clear_fault();
        cyc(R, R, R, R, 1'b1, 1'b1);
    endtask

    initial begin
        int g_ph, g_left, ns_next;
        logic [2:0] n, s, e, w;
        logic clr, r;

        cyc(R, R, R, R, 1'b0, 1'b0);
        cyc(R, R, R, R, 1'b0, 1'b0);
        chk("rst_fault", int'(fault), 0);
        chk("rst_code", int'(fault_code), 0);
        chk("rst_cnt", int'(fault_cnt), 0);

        hold(P_ALLR, 5);
        for (int k = 0; k < 3; k++) begin
            hold(P_NSG, 50); hold(P_NSY, 10); hold(P_ALLR, 5);
            hold(P_EWG, 50); hold(P_EWY, 10); hold(P_ALLR, 5);
        end
        chk("nominal_fault", int'(fault), 0);
        chk("nominal_cnt", int'(fault_cnt), 0);

        hold(P_NSG, 10);
        cyc(3'b110, G, R, R, 1'b0, 1'b1);
        chk("illegal_fault", int'(fault), 1);
        chk("illegal_code", int'(fault_code), 1);
        chk("illegal_cnt", int'(fault_cnt), 1);
        clear_fault();
        chk("clr_fault", int'(fault), 0);
        hold(P_ALLR, 2);
        hold(P_NSG, 1);
        chk("arm_exit_unchecked", int'(fault), 0);

        hold(P_NSG, 20); hold(P_NSY, 9); hold(P_ALLR, 1);
        chk("short_yellow_code", int'(fault_code), 5);
        clear_fault();
        hold(P_ALLR, 5); hold(P_NSG, 20); hold(P_NSY, 10); hold(P_ALLR, 5);
        chk("yellow_min_ok", int'(fault), 0);

        hold(P_EWG, 20); hold(P_EWY, 10); hold(P_ALLR, 5); hold(P_NSG, 20); hold(P_ALLR, 1);
        chk("sequence_code", int'(fault_code), 4);
        clear_fault();
        hold(P_ALLR, 5); hold(P_NSG, 20);
        cyc(G, G, Y, Y, 1'b0, 1'b1);
        chk("conflict_prio_code", int'(fault_code), 2);
        chk("conflict_prio_cnt", int'(fault_cnt), 4);
        clear_fault();

        hold(P_ALLR, 5); hold(P_NSG, 99); hold(P_NSY, 1);
        chk("stuck_99_ok", int'(fault), 0);
        hold(P_NSY, 9); hold(P_ALLR, 5); hold(P_NSG, 100); hold(P_NSY, 1);
`ifdef FWTS_MON_STUCK_EN
        chk("stuck_100_code", int'(fault_code), 7);
`else
        chk("stuck_off_fault", int'(fault), 0);
        cyc(3'b000, R, R, R, 1'b0, 1'b1);
        chk("illegal_zero_code", int'(fault_code), 1);
`endif
        clear_fault();
        cyc(G, G, G, G, 1'b1, 1'b1);
        chk("arm_clr_conflict_fault", int'(fault), 1);
        chk("arm_clr_conflict_code", int'(fault_code), 2);
        chk("arm_clr_conflict_cnt", int'(fault_cnt), 6);
        cyc(R, R, R, R, 1'b0, 1'b0);
        chk("midrst_fault", int'(fault), 0);
        chk("midrst_code", int'(fault_code), 0);
        chk("midrst_cnt", int'(fault_cnt), 0);

        g_ph = P_ALLR; g_left = 0; ns_next = 1;
        for (int i = 0; i < 4000; i++) begin
            if (g_left == 0) begin
                case (g_ph)
                    P_NSG: g_ph = P_NSY;
                    P_EWG: g_ph = P_EWY;
                    P_NSY, P_EWY: g_ph = P_ALLR;
                    default: begin
                        g_ph = (ns_next != 0) ? P_NSG : P_EWG;
                        ns_next = 1 - ns_next;
                    end
                endcase
                if ($urandom_range(0, 15) == 0) g_ph = int'($urandom_range(0, 4));
                case (g_ph)
                    P_NSG, P_EWG: g_left = ($urandom_range(0, 9) == 0) ?
                                           int'($urandom_range(95, 104)) : int'($urandom_range(1, 40));
                    P_NSY, P_EWY: g_left = int'($urandom_range(8, 12));
                    default:      g_left = int'($urandom_range(3, 7));
                endcase
            end
            g_left--;
            lamps(g_ph, n, s, e, w);
            if ($urandom_range(0, 59) == 0) begin
                n = 3'($urandom); s = 3'($urandom); e = 3'($urandom); w = 3'($urandom);
            end
            clr = ((m_mode == M_FAULT) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 99) == 0);
            r = ($urandom_range(0, 999) != 0);
            cyc(n, s, e, w, clr, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fwts_conflict_monitor.md
# fwts_conflict_monitor

Independent safety monitor on the receiving end of the four-way signal controller's lamp buses. It samples the north/south/east/west lamp codes every cycle and checks them for:
- illegal codes
- conflicting greens
- bad phase sequences
- short yellow or all-red intervals
- a stuck controller

On the first violation it latches a fault code and holds `fault` high, which the cabinet logic uses to force all-red.

## Interface
- `T_YELLOW_MIN`, 10, minimum cycles a yellow phase must be held
- `T_RED_MIN`, 5, minimum cycles of all-red clearance before any green
- `T_STUCK`, 100, cycles a phase may be held before it is declared stuck
- `CNT_W`, 8, width of the phase-duration counter; must hold `T_STUCK`
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, synchronous and active-low (0 = reset)
- `north`, `south`, `east`, `west`  in  3 each  lamp codes: RED=3'b001, YELLOW=3'b010, GREEN=3'b100
- `fault_clr`  in  1  single-cycle pulse that clears a latched fault
- `fault`  out  1  latched fault flag
- `fault_code`  out  3  code of the first fault since the last clear
- `fault_cnt`  out  8  number of faults latched since reset; saturates at 255

## Operation
- Phase classification of each cycle's inputs:
  - NS_G: N=S=GREEN, E=W=RED
  - NS_Y: N=S=YELLOW, E=W=RED
  - EW_G: E=W=GREEN, N=S=RED
  - EW_Y: E=W=YELLOW, N=S=RED
  - ALL_R: all four RED
  - otherwise INVALID
- Fault codes, lowest number wins when several occur in the same cycle:
  - 0 NONE
  - 1 ILLEGAL: a direction code is not one-hot (includes 000)
  - 2 CONFLICT: an N/S lamp and an E/W lamp are both non-RED
  - 3 PAIR: north≠south or east≠west, codes 1–2 not applicable
  - 4 SEQUENCE: phase change is not one of NS_G→NS_Y, NS_Y→ALL_R, EW_G→EW_Y, EW_Y→ALL_R, ALL_R→NS_G, ALL_R→EW_G. This includes a skipped yellow.
  - 5 SHORT_YELLOW: leaving NS_Y/EW_Y with duration < `T_YELLOW_MIN`
  - 6 SHORT_CLEAR: leaving ALL_R with duration < `T_RED_MIN`
  - 7 STUCK: duration reaches `T_STUCK`
- Duration counter:
  - Equals 1 on the first cycle of a new phase and increments each cycle the phase holds.
  - Saturates at 2^`CNT_W`−1.
  - A held duration exactly equal to a minimum passes.
- Monitor states:
  - ARM (reset value):
    - Codes 1, 2, 3 and 7 are checked.
    - On the first valid phase change, go to MONITOR without checking that change.
  - MONITOR: all codes are checked; any fault goes to FAULT.
  - FAULT:
    - `fault`=1 and `fault_code` is frozen.
    - `fault_clr`=1 goes to ARM, clears `fault`/`fault_code` and restarts the counter.
    - Inputs are ignored.
- Simultaneous events:
  - A fault detected in ARM/MONITOR in the same cycle as `fault_clr`: the fault is latched and the clear is ignored.
  - `fault_clr` outside FAULT has no effect.
- `fault_cnt` increments once per entry into FAULT.
- Reset mid-operation returns to ARM and zeroes every output and the counter.

## Timing
- Inputs are sampled on each rising edge and all outputs are registered.
- `fault` and `fault_code` rise one cycle after the edge that samples the offending inputs.
- `fault_cnt` updates on the same edge that sets `fault`.
- A `fault_clr` sampled high in FAULT drops `fault` on the next edge.
- Reset values: `fault`=0, `fault_code`=0, `fault_cnt`=0, state=ARM, previous phase=ALL_R, counter=0.
- STUCK timing: the fault is asserted on the edge after the counter reaches `T_STUCK`. Held for exactly `T_STUCK`−1 cycles, no fault.

## Configuration
- `FWTS_MON_STUCK_EN` defined: the STUCK check (code 7) is active.
- `FWTS_MON_STUCK_EN` undefined:
  - Code 7 is never produced and `T_STUCK` is unused.
  - The counter only needs to saturate at max(`T_YELLOW_MIN`, `T_RED_MIN`).

## Structure
- `fwts_pkg` holds:
  - lamp encodings RED/YELLOW/GREEN
  - the phase enum (NS_G, NS_Y, EW_G, EW_Y, ALL_R, INVALID)
  - the fault code constants 0–7
  - the monitor state enum
- One combinational sub-module, `fwts_phase_decode`, maps the four lamp codes to a phase plus ILLEGAL/CONFLICT/PAIR flags.
- The top level holds the counter, previous-phase register, state machine and fault registers.

## Test plan
- Drive the controller's nominal cycle (50 G / 10 Y / 5 R) for three full rotations → `fault` stays 0 and `fault_cnt`=0.
- Force north=3'b110 for one cycle in MONITOR → next cycle `fault`=1, `fault_code`=1, `fault_cnt`=1. Pulse `fault_clr` → `fault`=0 one cycle later and state is ARM.
- Drive NS_Y for 9 cycles then ALL_R, after a valid ARM exit → `fault_code`=5. Drive NS_Y for 10 cycles → no fault.
- Drive NS_G directly to ALL_R in MONITOR → `fault_code`=4. In the same cycle, also drive north=GREEN with east=YELLOW → `fault_code`=2 (priority).
- Hold NS_G for 100 cycles → `fault_code`=7 with the macro defined, no fault without it. Hold 99 cycles → no fault.
- Assert `fault_clr` in the same cycle as a new CONFLICT in ARM → `fault` stays 1 with `fault_code`=2. Assert reset mid-FAULT → all outputs 0 the next cycle.
